// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: takes valid/ready ALU requests, serialises operands onto the shared bus,
// strobes the A/B/F registers and returns the captured result over a response handshake.
module alu_seq_ctrl #(
  parameter int EXEC_WAIT = 2,
  parameter int OP_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] opnd_bus,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_f,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic [3:0]  alu_fr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_f,
  output logic [3:0]  rsp_fr,
  output logic        rsp_err,
  output logic [15:0] op_count
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, LOAD_F, CAPTURE, RESP} state_t;
  localparam logic [3:0] WAIT_LD = 4'(EXEC_WAIT - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]  fr_q, fr_d;
  logic        err_q, err_d;
  logic [15:0] op_count_q, op_count_d;
  logic        accept, illegal, done;
  assign accept  = state_q == IDLE && req_valid;
  assign illegal = int'(req_op) > OP_MAX;
  assign done    = state_q == RESP && rsp_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // EXEC is bypassed when no settle time is configured
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = illegal ? RESP : LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = (EXEC_WAIT == 0) ? LOAD_F : EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = LOAD_F;
      LOAD_F:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_q == LOAD_B ? WAIT_LD : state_q == EXEC ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    req_ready = state_q == IDLE;
    ld_a      = state_q == LOAD_A;
    ld_b      = state_q == LOAD_B;
    ld_f      = state_q == LOAD_F;
    rsp_valid = state_q == RESP;
    opnd_bus  = state_q == LOAD_A ? a_q : state_q == LOAD_B ? b_q : '0;
  end
  // alu_op only follows legal requests so a rejected opcode never reaches the ALU
  always_comb begin
    a_d        = accept ? req_a : a_q;
    b_d        = accept ? req_b : b_q;
    op_d       = accept && !illegal ? req_op : op_q;
    f_d        = accept && illegal ? '0 : state_q == CAPTURE ? alu_f : f_q;
    fr_d       = accept && illegal ? '0 : state_q == CAPTURE ? alu_fr : fr_q;
    err_d      = accept ? illegal : state_q == CAPTURE ? 1'b0 : err_q;
    op_count_d = done && !err_q ? op_count_q + 16'd1 : op_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      f_q        <= '0;
      fr_q       <= '0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      f_q        <= f_d;
      fr_q       <= fr_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end
  assign alu_op   = op_q;
  assign rsp_f    = f_q;
  assign rsp_fr   = fr_q;
  assign rsp_err  = err_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven check of the ALU sequencer against a small ALU register model.
module tb_alu_seq_ctrl;
  localparam int W = 2;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
    logic [3:0]  fr;
    logic        err;
    int          hold;
    bit          pre;
    bit          keep;
  } vec_t;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, rsp_ready = 0;
  logic [3:0]  req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic        req_ready, ld_a, ld_b, ld_f, rsp_valid, rsp_err;
  logic [31:0] opnd_bus, rsp_f, alu_f;
  logic [3:0]  alu_op, rsp_fr, alu_fr;
  logic [15:0] op_count;
  logic        req_valid_s = 0, rsp_ready_s = 1;
  logic        s0_rr, s0_la, s0_lb, s0_lf, s0_rv, s0_re;
  logic        s1_rr, s1_la, s1_lb, s1_lf, s1_rv, s1_re;
  logic [31:0] s0_bus, s0_f, s1_bus, s1_f;
  logic [3:0]  s0_op, s0_fr, s1_op, s1_fr;
  logic [15:0] s0_cnt, s1_cnt;
  logic [31:0] m_a, m_b, m_nf;
  int total = 0, bad = 0, ovl_bad = 0;
  logic [15:0] exp_cnt;
  logic [3:0]  last_op;
  int r_ta, r_tb, r_tf, r_tv, r_nstb, r_viol;
  logic [31:0] r_bus_a, r_bus_b, r_f;
  logic [3:0]  r_fr, r_opf, r_opv;
  logic        r_err, r_rdy, r_val;
  vec_t vecs[9];

  alu_seq_ctrl #(.EXEC_WAIT(W), .OP_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .opnd_bus(opnd_bus), .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f),
    .alu_op(alu_op), .alu_f(alu_f), .alu_fr(alu_fr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_fr(rsp_fr), .rsp_err(rsp_err), .op_count(op_count));
  alu_seq_ctrl #(.EXEC_WAIT(0), .OP_MAX(8)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(s0_rr), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .opnd_bus(s0_bus), .ld_a(s0_la), .ld_b(s0_lb), .ld_f(s0_lf),
    .alu_op(s0_op), .alu_f(32'hA5A5_0001), .alu_fr(4'h3), .rsp_valid(s0_rv), .rsp_ready(rsp_ready_s),
    .rsp_f(s0_f), .rsp_fr(s0_fr), .rsp_err(s0_re), .op_count(s0_cnt));
  alu_seq_ctrl #(.EXEC_WAIT(15), .OP_MAX(8)) dut_w15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(s1_rr), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .opnd_bus(s1_bus), .ld_a(s1_la), .ld_b(s1_lb), .ld_f(s1_lf),
    .alu_op(s1_op), .alu_f(32'hA5A5_0001), .alu_fr(4'h3), .rsp_valid(s1_rv), .rsp_ready(rsp_ready_s),
    .rsp_f(s1_f), .rsp_fr(s1_fr), .rsp_err(s1_re), .op_count(s1_cnt));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU register wrapper model: A/B load from the bus, F/FR computed at ld_f
  assign m_nf = alu_fn(alu_op, m_a, m_b);
  always_ff @(posedge clk) begin
    if (ld_a) m_a <= opnd_bus;
    if (ld_b) m_b <= opnd_bus;
    if (ld_f) begin
      alu_f  <= m_nf;
      alu_fr <= {m_nf == 32'd0, m_nf[31], 2'b00};
    end
  end

  always @(negedge clk)
    if (rst_n && !($onehot0({ld_a, ld_b, ld_f}) && $onehot0({s0_la, s0_lb, s0_lf}) && $onehot0({s1_la, s1_lb, s1_lf})))
      ovl_bad <= ovl_bad + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // starts at a negedge in an idle cycle (cycle 0); ends at the negedge after the handshake
  task automatic run_op(input vec_t v);
    int waited;
    bit done;
    r_ta = -1; r_tb = -1; r_tf = -1; r_tv = -1; r_nstb = 0; r_viol = 0;
    r_bus_a = 0; r_bus_b = 0; r_f = 0; r_fr = 0; r_opf = 0; r_opv = 0; r_err = 0;
    waited = 0; done = 0;
    req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1; rsp_ready = v.pre;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = v.keep;
      if (ld_a) begin r_ta = c; r_bus_a = opnd_bus; end
      if (ld_b) begin r_tb = c; r_bus_b = opnd_bus; end
      if (ld_f) begin r_tf = c; r_opf = alu_op; end
      if (ld_a || ld_b || ld_f) r_nstb++;
      if (req_ready) r_viol++;
      if (!ld_a && !ld_b && opnd_bus !== 32'd0) r_viol++;
      if (rsp_valid) begin
        if (r_tv < 0) begin
          r_tv = c; r_f = rsp_f; r_fr = rsp_fr; r_err = rsp_err; r_opv = alu_op;
        end else if ({rsp_f, rsp_fr, rsp_err} !== {r_f, r_fr, r_err}) r_viol++;
        if (waited >= v.hold) begin
          rsp_ready = 1; req_valid = 0; done = 1;
        end else waited++;
      end
    end
    @(negedge clk);
    rsp_ready = 0;
    r_rdy = req_ready;
    r_val = rsp_valid;
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d_", idx);
    run_op(v);
    chk({p, "t_ld_a"}, r_ta, v.err ? -1 : 1);
    chk({p, "t_ld_b"}, r_tb, v.err ? -1 : 2);
    chk({p, "t_ld_f"}, r_tf, v.err ? -1 : 3 + W);
    chk({p, "t_valid"}, r_tv, v.err ? 1 : 5 + W);
    chk({p, "bus_a"}, r_bus_a, v.err ? 32'd0 : v.a);
    chk({p, "bus_b"}, r_bus_b, v.err ? 32'd0 : v.b);
    chk({p, "op_at_ld_f"}, r_opf, v.err ? 4'd0 : v.op);
    chk({p, "op_at_rsp"}, r_opv, v.err ? last_op : v.op);
    chk({p, "rsp_f"}, r_f, v.f);
    chk({p, "rsp_fr"}, r_fr, v.fr);
    chk({p, "rsp_err"}, r_err, v.err);
    chk({p, "strobes"}, r_nstb, v.err ? 0 : 3);
    chk({p, "busy_viol"}, r_viol, 0);
    chk({p, "ready_after"}, r_rdy, 1);
    chk({p, "valid_after"}, r_val, 0);
    if (!v.err) begin
      exp_cnt = exp_cnt + 16'd1;
      last_op = v.op;
    end
    chk({p, "op_count"}, op_count, exp_cnt);
  endtask

  initial begin
    int sw_tf0, sw_tv0, sw_tf1, sw_tv1, sw_ta0, sw_tb0, nstb;
    logic [31:0] sw_f0, sw_f1;
    vec_t v;
    vecs[0] = '{4'd1,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'h0, 1'b0, 0,  1'b0, 1'b0};
    vecs[1] = '{4'd2,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'h4, 1'b0, 0,  1'b0, 1'b0};
    vecs[2] = '{4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'h8, 1'b0, 10, 1'b0, 1'b1};
    vecs[3] = '{4'hF,  32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 4'h0, 1'b1, 0,  1'b0, 1'b0};
    vecs[4] = '{4'd9,  32'h3333_3333, 32'h4444_4444, 32'h0000_0000, 4'h0, 1'b1, 2,  1'b0, 1'b1};
    vecs[5] = '{4'd8,  32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 4'h0, 1'b0, 0,  1'b1, 1'b0};
    vecs[6] = '{4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'h4, 1'b0, 3,  1'b0, 1'b0};
    vecs[7] = '{4'd0,  32'h0000_0000, 32'h0000_0007, 32'h0000_0000, 4'h8, 1'b0, 0,  1'b0, 1'b0};
    vecs[8] = '{4'd4,  32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'h4, 1'b0, 0,  1'b0, 1'b0};
    exp_cnt = 0;
    last_op = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_strobes", {ld_a, ld_b, ld_f}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_f", rsp_f, 0);
    chk("rst_rsp_fr", rsp_fr, 0);
    chk("rst_bus", opnd_bus, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_op_count", op_count, 0);

    for (int i = 0; i < 9; i++) do_vec(vecs[i], i);

    // reset asserted during the EXEC phase of an op
    req_op = 4'd1; req_a = 32'd7; req_b = 32'd9; req_valid = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 0;
      if (c == 4) rst_n = 0;
    end
    @(negedge clk);
    chk("mid_rst_ld_f", ld_f, 0);
    chk("mid_rst_strobes", {ld_a, ld_b}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_bus", opnd_bus, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_rsp_f", rsp_f, 0);
    rst_n = 1;
    nstb = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ld_a || ld_b || ld_f || rsp_valid) nstb++;
    end
    chk("mid_rst_quiet", nstb, 0);
    chk("mid_rst_ready", req_ready, 1);
    exp_cnt = 0;
    last_op = 0;
    v = '{4'd1, 32'd7, 32'd9, 32'd16, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    do_vec(v, 20);

    // op_count wrap from 0xFFFF
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    chk("wrap_preload", op_count, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    v = '{4'd2, 32'd10, 32'd4, 32'd6, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    do_vec(v, 30);
    v = '{4'hC, 32'd1, 32'd2, 32'd0, 4'h0, 1'b1, 0, 1'b0, 1'b0};
    do_vec(v, 31);

    // EXEC_WAIT sweep on the 0 and 15 instances, rsp_ready already high
    sw_tf0 = -1; sw_tv0 = -1; sw_tf1 = -1; sw_tv1 = -1; sw_ta0 = -1; sw_tb0 = -1;
    sw_f0 = 0; sw_f1 = 0;
    req_op = 4'd1; req_a = 32'd1; req_b = 32'd2; req_valid_s = 1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) req_valid_s = 0;
      if (s0_la && sw_ta0 < 0) sw_ta0 = c;
      if (s0_lb && sw_tb0 < 0) sw_tb0 = c;
      if (s0_lf && sw_tf0 < 0) sw_tf0 = c;
      if (s1_lf && sw_tf1 < 0) sw_tf1 = c;
      if (s0_rv && sw_tv0 < 0) begin sw_tv0 = c; sw_f0 = s0_f; end
      if (s1_rv && sw_tv1 < 0) begin sw_tv1 = c; sw_f1 = s1_f; end
    end
    chk("w0_ld_a", sw_ta0, 1);
    chk("w0_ld_b", sw_tb0, 2);
    chk("w0_ld_f", sw_tf0, 3);
    chk("w0_valid", sw_tv0, 5);
    chk("w0_rsp_f", sw_f0, 32'hA5A5_0001);
    chk("w15_ld_f", sw_tf1, 18);
    chk("w15_valid", sw_tv1, 20);
    chk("w15_rsp_f", sw_f1, 32'hA5A5_0001);
    chk("w0_count", s0_cnt, 1);
    chk("w15_count", s1_cnt, 1);
    chk("w15_idle", s1_rr, 1);

    chk("strobe_excl", ovl_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
